// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bus bundle: memory request/response channel, redirect input
// from execute, and the {instr, instr_pc} valid/ready channel to decode.
// Modports:
//   master - the fetch unit (drives memory requests and the decode channel)
//   slave  - the environment (memory, execute, decode)
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage. Holds the fetch PC, issues in-order word reads to
// instruction memory, tracks the PCs of in-flight reads, and buffers returned
// instructions with their PCs in a FIFO that feeds decode over valid/ready.
// A redirect from execute reloads the PC, empties the FIFO and marks every
// still-outstanding read to be discarded when its response arrives.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   bus (master)  - imem_req_*, imem_rsp_*, redirect_*, instr_* (see interface)
//   perf_fetched  - FIFO push count        (only with FETCH_PERF_EN)
//   perf_stall    - cycles with no instr   (only with FETCH_PERF_EN)
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
`ifdef FETCH_PERF_EN
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall,
`endif
    instr_fetch_unit_if.master  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_r;
    logic [31:0]   fifo_instr_r [FIFO_DEPTH];
    logic [31:0]   fifo_pc_r    [FIFO_DEPTH];
    logic [PW-1:0] fifo_rd_r;
    logic [PW-1:0] fifo_wr_r;
    logic [CW-1:0] fifo_cnt_r;
    logic [31:0]   pcq_r        [FIFO_DEPTH];
    logic [PW-1:0] pcq_rd_r;
    logic [PW-1:0] pcq_wr_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;

    logic [CW:0]   credit_sum_s;
    logic          req_valid_s;
    logic          accept_s;
    logic          rsp_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_ne_s;
    logic          unused_redirect_lsb_s;

    // Redirect target is word aligned; its low bits carry no information.
    assign unused_redirect_lsb_s = ^bus.redirect_pc[1:0];

    // Handshake qualifiers. Credits count buffered plus in-flight words, and a
    // pop in the same cycle is deliberately not credited so instr_ready never
    // reaches imem_req_valid combinationally.
    always_comb begin
        credit_sum_s = {1'b0, fifo_cnt_r} + {1'b0, outstanding_r};
        req_valid_s  = !rst && !bus.redirect_valid
                       && (credit_sum_s < (CW+1)'(FIFO_DEPTH));
        accept_s     = req_valid_s && bus.imem_req_ready;
        rsp_s        = bus.imem_rsp_valid && (outstanding_r != {CW{1'b0}});
        fifo_ne_s    = (fifo_cnt_r != {CW{1'b0}});
        push_s       = rsp_s && (drop_cnt_r == {CW{1'b0}}) && !bus.redirect_valid;
        pop_s        = fifo_ne_s && bus.instr_ready && !bus.redirect_valid;
    end

    // Fetch PC, in-flight PC queue, outstanding and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            pcq_rd_r      <= {PW{1'b0}};
            pcq_wr_r      <= {PW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pcq_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (bus.redirect_valid) begin
                fetch_pc_r <= {bus.redirect_pc[31:2], 2'b00};
            end else if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (accept_s) begin
                pcq_r[pcq_wr_r] <= fetch_pc_r;
                pcq_wr_r        <= pcq_wr_r + PW'(1);
            end
            if (rsp_s) begin
                pcq_rd_r <= pcq_rd_r + PW'(1);
            end
            outstanding_r <= outstanding_r + CW'(accept_s) - CW'(rsp_s);
            // Everything still in flight after this cycle belongs to the old path.
            if (bus.redirect_valid) begin
                drop_cnt_r <= outstanding_r - CW'(rsp_s);
            end else if (rsp_s && (drop_cnt_r != {CW{1'b0}})) begin
                drop_cnt_r <= drop_cnt_r - CW'(1);
            end
        end
    end

    // Instruction FIFO; a redirect empties it and discards same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_rd_r  <= {PW{1'b0}};
            fifo_wr_r  <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_r[i] <= 32'h0000_0000;
                fifo_pc_r[i]    <= 32'h0000_0000;
            end
        end else if (bus.redirect_valid) begin
            fifo_rd_r  <= {PW{1'b0}};
            fifo_wr_r  <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_instr_r[fifo_wr_r] <= bus.imem_rsp_data;
                fifo_pc_r[fifo_wr_r]    <= pcq_r[pcq_rd_r];
                fifo_wr_r               <= fifo_wr_r + PW'(1);
            end
            if (pop_s) begin
                fifo_rd_r <= fifo_rd_r + PW'(1);
            end
            fifo_cnt_r <= fifo_cnt_r + CW'(push_s) - CW'(pop_s);
        end
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.instr_valid    = fifo_ne_s;
    assign bus.instr          = fifo_ne_s ? fifo_instr_r[fifo_rd_r] : 32'h0000_0000;
    assign bus.instr_pc       = fifo_ne_s ? fifo_pc_r[fifo_rd_r]    : 32'h0000_0000;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;

    // Performance counters: words buffered and cycles with nothing for decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_r <= 32'h0000_0000;
            perf_stall_r   <= 32'h0000_0000;
        end else begin
            perf_fetched_r <= perf_fetched_r + 32'(push_s);
            perf_stall_r   <= perf_stall_r + 32'(!fifo_ne_s);
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_stall   = perf_stall_r;
`endif
endmodule
